// File: rtl/mux_scan_sequencer_pkg.sv
// Shared definitions for the 4-channel mux scan sequencer.
// Holds the FSM state encoding, the channel index width and default timing.
// No logic; pure types and constants.
package mux_scan_sequencer_pkg;

    // Two select lines address four mux channels
    localparam int CH_W           = 2;
    // Default number of cycles each select code is held before sampling
    localparam int SETTLE_DEFAULT = 2;
    // Settle counter width, enough for the largest legal settle time (15)
    localparam int CNT_W          = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/mux_scan_sequencer_settle_counter.sv
// Settle timer: counts cycles spent on the current select code.
// Latency: count updates one edge after load/inc; tc is combinational from the count register.
// Backpressure: none; the parent decides when to load or increment.
module settle_counter
    import mux_scan_sequencer_pkg::*;
#(
    parameter int SETTLE_CYCLES = SETTLE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_inc,
    output logic o_tc
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(SETTLE_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    // Load (to zero) wins over increment so a channel change always restarts the settle window
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tc = (r_count == TC_VAL);

endmodule

// File: rtl/mux_scan_sequencer.sv
// Drives a 4x1 mux select through channels 0..3, sampling mux_in after a settle time on each.
// Latency: valid rises 4*SETTLE_CYCLES edges after the edge that samples start.
// Backpressure: result is held in DONE until ack; start is ignored while scanning.
module mux_scan_sequencer
    import mux_scan_sequencer_pkg::*;
#(
    parameter int SETTLE_CYCLES = SETTLE_DEFAULT,
    parameter bit CONTINUOUS    = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       mux_in,
    input  logic       ack,
    output logic       s0,
    output logic       s1,
    output logic [3:0] sample,
    output logic       valid,
    output logic       busy
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CH_W-1:0]   r_channel;
    logic [CH_W-1:0]   w_channel_nxt;
    logic [2:0]        r_shadow;
    logic [2:0]        w_shadow_nxt;
    logic              w_cnt_load;
    logic              w_cnt_inc;
    logic              w_cnt_tc;
    logic              w_sample_load;
    logic              w_valid_nxt;
    logic [CH_W-1:0]   w_sel_nxt;

    logic              r_s0;
    logic              r_s1;
    logic [3:0]        r_sample;
    logic              r_valid;
    logic              r_busy;

    settle_counter #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_counter (
        .clk   (clk),
        .rst   (rst),
        .i_load(w_cnt_load),
        .i_inc (w_cnt_inc),
        .o_tc  (w_cnt_tc)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, channel stepping, shadow capture and settle-counter control
    always_comb begin
        w_state_nxt   = r_state;
        w_channel_nxt = r_channel;
        w_shadow_nxt  = r_shadow;
        w_cnt_load    = 1'b0;
        w_cnt_inc     = 1'b0;
        w_sample_load = 1'b0;
        w_valid_nxt   = r_valid;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt   = SETTLE;
                    w_channel_nxt = '0;
                    w_cnt_load    = 1'b1;
                end
            end
            SETTLE: begin
                if (w_cnt_tc) begin
                    // Channel 3 is never stored in the shadow; it goes straight into sample
                    case (r_channel)
                        2'd0:    w_shadow_nxt[0] = mux_in;
                        2'd1:    w_shadow_nxt[1] = mux_in;
                        2'd2:    w_shadow_nxt[2] = mux_in;
                        default: w_shadow_nxt    = r_shadow;
                    endcase
                    w_cnt_load = 1'b1;
                    if (r_channel == 2'd3) begin
                        w_state_nxt   = DONE;
                        w_channel_nxt = '0;
                        w_sample_load = 1'b1;
                        w_valid_nxt   = 1'b1;
                    end else begin
                        w_channel_nxt = r_channel + 1'b1;
                    end
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            DONE: begin
                if (ack) begin
                    w_valid_nxt   = 1'b0;
                    w_channel_nxt = '0;
                    if (CONTINUOUS || start) begin
                        w_state_nxt = SETTLE;
                        w_cnt_load  = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt   = IDLE;
                w_channel_nxt = '0;
                w_cnt_load    = 1'b1;
                w_valid_nxt   = 1'b0;
            end
        endcase
        // Select lines follow the channel only while scanning, otherwise park at 0
        w_sel_nxt = (w_state_nxt == SETTLE) ? w_channel_nxt : '0;
    end

    // Datapath and output registers; nothing reaches an output without passing a flop
    always_ff @(posedge clk) begin
        if (rst) begin
            r_channel <= '0;
            r_shadow  <= '0;
            r_s0      <= 1'b0;
            r_s1      <= 1'b0;
            r_sample  <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_channel <= w_channel_nxt;
            r_shadow  <= w_shadow_nxt;
            r_s0      <= w_sel_nxt[0];
            r_s1      <= w_sel_nxt[1];
            r_valid   <= w_valid_nxt;
            r_busy    <= (w_state_nxt == SETTLE);
            if (w_sample_load) begin
                r_sample <= {mux_in, r_shadow};
            end
        end
    end

    assign s0     = r_s0;
    assign s1     = r_s1;
    assign sample = r_sample;
    assign valid  = r_valid;
    assign busy   = r_busy;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer with a behavioural 4x1 mux on each instance.
// Four instances: default, continuous, fastest settle (1) and slowest settle (15).
// Inputs driven 1 time unit after the rising edge, outputs checked at the same point.
module tb_mux_scan_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // Default instance (SETTLE_CYCLES=2, CONTINUOUS=0)
    logic       start_a = 1'b0, ack_a = 1'b0, mux_a;
    logic       s0_a, s1_a, valid_a, busy_a;
    logic [3:0] sample_a;
    logic [3:0] data_a = 4'b0000;

    // Continuous instance
    logic       start_c = 1'b0, ack_c = 1'b0, mux_c;
    logic       s0_c, s1_c, valid_c, busy_c;
    logic [3:0] sample_c;
    logic [3:0] data_c = 4'b0000;

    // SETTLE_CYCLES=1 instance
    logic       start_f = 1'b0, ack_f = 1'b0, mux_f;
    logic       s0_f, s1_f, valid_f, busy_f;
    logic [3:0] sample_f;
    logic [3:0] data_f = 4'b0000;

    // SETTLE_CYCLES=15 instance
    logic       start_l = 1'b0, ack_l = 1'b0, mux_l;
    logic       s0_l, s1_l, valid_l, busy_l;
    logic [3:0] sample_l;
    logic [3:0] data_l = 4'b0000;

    int checks = 0;
    int errors = 0;

    // Mux models: data bit i is channel i (a=bit0 .. d=bit3)
    assign mux_a = data_a[{s1_a, s0_a}];
    assign mux_c = data_c[{s1_c, s0_c}];
    assign mux_f = data_f[{s1_f, s0_f}];
    assign mux_l = data_l[{s1_l, s0_l}];

    always #5 clk = ~clk;

    mux_scan_sequencer #(.SETTLE_CYCLES(2), .CONTINUOUS(1'b0)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .mux_in(mux_a), .ack(ack_a),
        .s0(s0_a), .s1(s1_a), .sample(sample_a), .valid(valid_a), .busy(busy_a)
    );

    mux_scan_sequencer #(.SETTLE_CYCLES(2), .CONTINUOUS(1'b1)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .mux_in(mux_c), .ack(ack_c),
        .s0(s0_c), .s1(s1_c), .sample(sample_c), .valid(valid_c), .busy(busy_c)
    );

    mux_scan_sequencer #(.SETTLE_CYCLES(1), .CONTINUOUS(1'b0)) dut_f (
        .clk(clk), .rst(rst), .start(start_f), .mux_in(mux_f), .ack(ack_f),
        .s0(s0_f), .s1(s1_f), .sample(sample_f), .valid(valid_f), .busy(busy_f)
    );

    mux_scan_sequencer #(.SETTLE_CYCLES(15), .CONTINUOUS(1'b0)) dut_l (
        .clk(clk), .rst(rst), .start(start_l), .mux_in(mux_l), .ack(ack_l),
        .s0(s0_l), .s1(s1_l), .sample(sample_l), .valid(valid_l), .busy(busy_l)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({s1_a, s0_a, sample_a, valid_a, busy_a} !== 8'h00) begin
            errors++;
            $display("FAIL reset_a outputs got %b exp 00000000", {s1_a, s0_a, sample_a, valid_a, busy_a});
        end
        checks++;
        if ({s1_c, s0_c, sample_c, valid_c, busy_c} !== 8'h00) begin
            errors++;
            $display("FAIL reset_c outputs got %b exp 00000000", {s1_c, s0_c, sample_c, valid_c, busy_c});
        end
        checks++;
        if ({s1_f, s0_f, sample_f, valid_f, busy_f} !== 8'h00) begin
            errors++;
            $display("FAIL reset_f outputs got %b exp 00000000", {s1_f, s0_f, sample_f, valid_f, busy_f});
        end
        checks++;
        if ({s1_l, s0_l, sample_l, valid_l, busy_l} !== 8'h00) begin
            errors++;
            $display("FAIL reset_l outputs got %b exp 00000000", {s1_l, s0_l, sample_l, valid_l, busy_l});
        end
        rst = 1'b0;
        step();
    endtask

    // a=1,b=0,c=1,d=1: select steps 00,01,10,11 two cycles each, valid on edge 8
    task automatic test_basic_scan();
        logic [1:0] exp_sel;
        data_a  = 4'b1101;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        checks++;
        if ({s1_a, s0_a, busy_a, valid_a} !== 4'b0010) begin
            errors++;
            $display("FAIL basic_first_edge sel/busy/valid got %b exp 0010", {s1_a, s0_a, busy_a, valid_a});
        end
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k < 8) begin
                exp_sel = 2'(k / 2);
                checks++;
                if ({s1_a, s0_a, busy_a, valid_a} !== {exp_sel, 2'b10}) begin
                    errors++;
                    $display("FAIL basic_edge%0d sel/busy/valid got %b exp %b", k, {s1_a, s0_a, busy_a, valid_a}, {exp_sel, 2'b10});
                end
            end else begin
                checks++;
                if ({sample_a, valid_a, busy_a} !== 6'b1101_10) begin
                    errors++;
                    $display("FAIL basic_done sample/valid/busy got %b exp 110110", {sample_a, valid_a, busy_a});
                end
            end
        end
    endtask

    // Result held while ack low; start in DONE without ack has no effect
    task automatic test_hold_ack();
        for (int i = 0; i < 5; i++) begin
            start_a = (i == 1 || i == 3);
            step();
            checks++;
            if ({sample_a, valid_a, busy_a} !== 6'b1101_10) begin
                errors++;
                $display("FAIL hold_cycle%0d sample/valid/busy got %b exp 110110", i, {sample_a, valid_a, busy_a});
            end
        end
        start_a = 1'b0;
        ack_a   = 1'b1;
        step();
        ack_a = 1'b0;
        checks++;
        if ({s1_a, s0_a, valid_a, busy_a, sample_a} !== 8'b0000_1101) begin
            errors++;
            $display("FAIL hold_ack sel/valid/busy/sample got %b exp 00001101", {s1_a, s0_a, valid_a, busy_a, sample_a});
        end
        step();
        checks++;
        if ({valid_a, busy_a} !== 2'b00) begin
            errors++;
            $display("FAIL hold_idle valid/busy got %b exp 00", {valid_a, busy_a});
        end
    endtask

    // ack while nothing is valid must not start or change anything
    task automatic test_ack_ignored();
        ack_a = 1'b1;
        step();
        ack_a = 1'b0;
        step();
        checks++;
        if ({valid_a, busy_a, sample_a} !== 6'b00_1101) begin
            errors++;
            $display("FAIL ack_idle valid/busy/sample got %b exp 001101", {valid_a, busy_a, sample_a});
        end
    endtask

    // Reset on the third scan cycle clears everything; next start rescans from channel 0
    task automatic test_midscan_reset();
        int n;
        data_a  = 4'b0110;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({s1_a, s0_a, sample_a, valid_a, busy_a} !== 8'h00) begin
            errors++;
            $display("FAIL midscan_reset outputs got %b exp 00000000", {s1_a, s0_a, sample_a, valid_a, busy_a});
        end
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        checks++;
        if ({s1_a, s0_a, busy_a} !== 3'b001) begin
            errors++;
            $display("FAIL rescan_start sel/busy got %b exp 001", {s1_a, s0_a, busy_a});
        end
        n = 0;
        while (!valid_a && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL rescan_latency edges got %0d exp 8", n);
        end
        checks++;
        if (sample_a !== 4'b0110) begin
            errors++;
            $display("FAIL rescan_sample got %b exp 0110", sample_a);
        end
    endtask

    // start+ack together in DONE restarts at channel 0; start mid-scan is ignored
    task automatic test_back_to_back();
        int n;
        data_a  = 4'b1001;
        start_a = 1'b1;
        ack_a   = 1'b1;
        step();
        start_a = 1'b0;
        ack_a   = 1'b0;
        checks++;
        if ({s1_a, s0_a, valid_a, busy_a} !== 4'b0001) begin
            errors++;
            $display("FAIL b2b_restart sel/valid/busy got %b exp 0001", {s1_a, s0_a, valid_a, busy_a});
        end
        n = 0;
        while (!valid_a && n < 100) begin
            start_a = (n == 3);
            step();
            n++;
        end
        start_a = 1'b0;
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL b2b_latency edges got %0d exp 8", n);
        end
        checks++;
        if (sample_a !== 4'b1001) begin
            errors++;
            $display("FAIL b2b_sample got %b exp 1001", sample_a);
        end
        ack_a = 1'b1;
        step();
        ack_a = 1'b0;
        checks++;
        if ({valid_a, busy_a} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_release valid/busy got %b exp 00", {valid_a, busy_a});
        end
    endtask

    // Continuous mode: after ack the next scan runs without a start pulse
    task automatic test_continuous();
        int n;
        data_c  = 4'b1101;
        start_c = 1'b1;
        step();
        start_c = 1'b0;
        n = 0;
        while (!valid_c && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (n != 8 || sample_c !== 4'b1101) begin
            errors++;
            $display("FAIL cont_first edges/sample got %0d/%b exp 8/1101", n, sample_c);
        end
        data_c = 4'b0010;
        ack_c  = 1'b1;
        step();
        ack_c = 1'b0;
        checks++;
        if ({s1_c, s0_c, valid_c, busy_c} !== 4'b0001) begin
            errors++;
            $display("FAIL cont_restart sel/valid/busy got %b exp 0001", {s1_c, s0_c, valid_c, busy_c});
        end
        n = 0;
        while (!valid_c && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL cont_latency edges got %0d exp 8", n);
        end
        checks++;
        if (sample_c !== 4'b0010) begin
            errors++;
            $display("FAIL cont_sample got %b exp 0010", sample_c);
        end
    endtask

    // Settle time extremes: 1 cycle (valid after 4 edges) and 15 cycles (after 60)
    task automatic test_settle_extremes();
        int n;
        data_f  = 4'b0101;
        start_f = 1'b1;
        step();
        start_f = 1'b0;
        n = 0;
        while (!valid_f && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL fast_latency edges got %0d exp 4", n);
        end
        checks++;
        if (sample_f !== 4'b0101) begin
            errors++;
            $display("FAIL fast_sample got %b exp 0101", sample_f);
        end

        data_l  = 4'b1010;
        start_l = 1'b1;
        step();
        start_l = 1'b0;
        n = 0;
        while (!valid_l && n < 100) begin
            step();
            n++;
            if (n == 20) begin
                checks++;
                if ({s1_l, s0_l, busy_l} !== 3'b011) begin
                    errors++;
                    $display("FAIL slow_midscan sel/busy got %b exp 011", {s1_l, s0_l, busy_l});
                end
            end
        end
        checks++;
        if (n != 60) begin
            errors++;
            $display("FAIL slow_latency edges got %0d exp 60", n);
        end
        checks++;
        if (sample_l !== 4'b1010) begin
            errors++;
            $display("FAIL slow_sample got %b exp 1010", sample_l);
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_hold_ack();
        test_ack_ignored();
        test_midscan_reset();
        test_back_to_back();
        test_continuous();
        test_settle_extremes();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_scan_sequencer.md
MUX_SCAN_SEQUENCER -- requirements
Module: mux_scan_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, legal range 1..15: clock cycles each select code is held before `mux_in` is sampled.
REQ-002 SHALL have parameter CONTINUOUS, default 0: 1 restarts the scan automatically after each acknowledged result.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request one scan of all four mux channels.
REQ-006 SHALL have port mux_in, input, 1 bit: output of the downstream 4x1 mux, fed back for sampling.
REQ-007 SHALL have port ack, input, 1 bit: consumer accepts the presented sample.
REQ-008 SHALL have ports s0 and s1, output, 1 bit each: registered select lines driving the mux; channel index = {s1,s0}.
REQ-009 SHALL have port sample, output, 4 bits: captured channel values; bit i = mux_in observed with {s1,s0}=i.
REQ-010 SHALL have port valid, output, 1 bit: sample holds a complete scan.
REQ-011 SHALL have port busy, output, 1 bit: a scan is in progress.

Function
REQ-012 SHALL implement FSM states IDLE, SETTLE and DONE.
REQ-013 IDLE SHALL hold s0=s1=0 and busy=0; start=1 SHALL move to SETTLE with channel=0 and settle count=0.
REQ-014 SETTLE SHALL drive {s1,s0}=channel, hold busy=1 and increment the settle count each cycle.
REQ-015 On the SETTLE cycle where count==SETTLE_CYCLES-1, the block SHALL capture mux_in into shadow bit [channel].
REQ-016 On that same cycle, if channel<3 the block SHALL increment channel and clear the count; if channel==3 it SHALL go to DONE.
REQ-017 On entry to DONE, sample SHALL load the four shadow bits, with bit 3 taken directly from mux_in; valid SHALL be 1 and busy SHALL be 0.
REQ-018 Latency: valid SHALL rise exactly 4*SETTLE_CYCLES rising edges after the edge that samples start (8 edges at the default).
REQ-019 DONE SHALL hold sample and valid stable until ack=1 is sampled.
REQ-020 In DONE with ack=1, valid SHALL clear on that edge; the next state SHALL be SETTLE at channel 0 if CONTINUOUS=1 or start=1, else IDLE.
REQ-021 start SHALL be ignored in SETTLE; ack SHALL be ignored when valid=0.
REQ-022 sample SHALL change only on DONE entry or reset.
REQ-023 Channel wrap: the block SHALL never increment the channel past 3; the scan order SHALL be fixed at 0,1,2,3.

Reset
REQ-024 rst=1 SHALL, at the next rising edge and from any state including mid-scan, force IDLE, s0=s1=0, sample=0, valid=0, busy=0, channel=0, count=0 and shadow=0.
REQ-025 rst SHALL take priority over start and ack in the same cycle.

Structure
REQ-026 A shared package SHALL hold the FSM state encoding, the channel-index width (2) and the default SETTLE_CYCLES.
REQ-027 The settle counter (load, increment, terminal-count flag) SHALL be a sub-module named settle_counter.
REQ-028 All outputs SHALL be registered; there SHALL be no combinational path from mux_in to any output.

Verification
REQ-029 With the mux model a=1,b=0,c=1,d=1 and a one-cycle start pulse: {s1,s0} SHALL step 00,01,10,11 for 2 cycles each; valid SHALL rise 8 edges after start; sample SHALL be 4'b1101.
REQ-030 With valid=1 and ack held low for 5 cycles: sample and valid SHALL stay stable; start pulses during this time SHALL have no effect; ack=1 SHALL drive valid to 0 and the state to IDLE.
REQ-031 With rst=1 asserted on the 3rd cycle of a scan: all outputs SHALL be 0 on the next edge; a following start SHALL rescan from channel 0.
REQ-032 With CONTINUOUS=1 and the inputs changed to a=0,b=1,c=0,d=0 between scans: after ack, the next result SHALL be 4'b0010 with no start pulse.
REQ-033 With SETTLE_CYCLES=1: valid SHALL rise 4 edges after start; with SETTLE_CYCLES=15: valid SHALL rise 60 edges after start, with correct sample in both cases.
REQ-034 With start and ack both high in DONE (CONTINUOUS=0): valid SHALL clear and a new scan SHALL begin at channel 0 on that edge.
